// File: rtl/tech_ram_tp.sv
// Behavioural two-port SRAM: one byte-masked write port, one read port with
// 1- or 2-cycle latency, selectable read-during-write policy, zero-fill sweep.
`ifndef REGISTER_DELAY
`define REGISTER_DELAY
`endif

module tech_ram_tp #(
  parameter int BIT_WIDTH  = 32,
  parameter int WORD_DEPTH = 64,
  parameter int RD_LAT     = 1,
  parameter int RDW_NEW    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic                          init_done_o,
  input  logic                          wr_en_i,
  input  logic [BIT_WIDTH/8-1:0]        wr_bm_i,
  input  logic [$clog2(WORD_DEPTH)-1:0] wr_addr_i,
  input  logic [BIT_WIDTH-1:0]          wr_dat_i,
  input  logic                          rd_en_i,
  input  logic [$clog2(WORD_DEPTH)-1:0] rd_addr_i,
  output logic [BIT_WIDTH-1:0]          rd_dat_o,
  output logic                          rd_vld_o
);

  localparam int NB = BIT_WIDTH / 8;
  localparam int AW = $clog2(WORD_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(WORD_DEPTH);

`ifdef BACKEND
  $error("tech_ram_tp: behavioural model, substitute a technology macro");
`endif

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("tech_ram_tp: RD_LAT must be 1 or 2");
  end
  if (BIT_WIDTH % 8 != 0) begin : g_bad_width
    $error("tech_ram_tp: BIT_WIDTH must be a multiple of 8");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state, state_next;
  logic [AW-1:0]          cnt;
  logic                   done;
  logic                   wr, rd, rd_in;
  logic [BIT_WIDTH-1:0]   word;
  logic                   vld1;
  logic [BIT_WIDTH-1:0]   dat1;
  logic [BIT_WIDTH-1:0]   mem [WORD_DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= (INIT_EN != 0) ? INIT : RUN;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == RUN);
      if (state == INIT) cnt <= cnt + AW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && cnt == AW'(WORD_DEPTH - 1)) state_next = RUN;
  end

  assign init_done_o = done;

  // Port operations are accepted only once the memory is reported usable.
  assign wr    = done && !wr_en_i && ({1'b0, wr_addr_i} < DEPTH);
  assign rd    = done && !rd_en_i;
  assign rd_in = ({1'b0, rd_addr_i} < DEPTH);

  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[cnt] <= `REGISTER_DELAY '0;
    end else if (wr) begin
      for (int unsigned i = 0; i < NB; i++)
        if (wr_bm_i[i]) mem[wr_addr_i][8*i +: 8] <= `REGISTER_DELAY wr_dat_i[8*i +: 8];
    end
  end

  // The array read sees pre-edge contents; RDW_NEW forwards the masked write bytes.
  always_comb begin
    word = '0;
    if (rd_in) begin
      word = mem[rd_addr_i];
      if (RDW_NEW != 0 && wr && wr_addr_i == rd_addr_i)
        for (int unsigned i = 0; i < NB; i++)
          if (wr_bm_i[i]) word[8*i +: 8] = wr_dat_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld1 <= 1'b0;
      dat1 <= '0;
    end else begin
      vld1 <= rd;
      if (rd) dat1 <= `REGISTER_DELAY word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                 vld2;
    logic [BIT_WIDTH-1:0] dat2;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld2 <= 1'b0;
        dat2 <= '0;
      end else begin
        vld2 <= vld1;
        if (vld1) dat2 <= `REGISTER_DELAY dat1;
      end
    end

    assign rd_vld_o = vld2;
    assign rd_dat_o = dat2;
  end else begin : g_lat1
    assign rd_vld_o = vld1;
    assign rd_dat_o = dat1;
  end

endmodule

// File: tb/tb_tech_ram_tp.sv
// Bench for tech_ram_tp: three configurations share one stimulus stream and are
// compared every cycle against a word/byte-level memory model with a read scoreboard.
module tb_tech_ram_tp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [3:0]  wr_bm;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_dat;
  logic [2:0]  done, vld;
  logic [31:0] dat [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tech_ram_tp #(.BIT_WIDTH(32), .WORD_DEPTH(16), .RD_LAT(1), .RDW_NEW(0), .INIT_EN(1)) u_a (
    .clk_i(clk), .rst_i(rst), .init_done_o(done[0]), .wr_en_i(wr_en), .wr_bm_i(wr_bm),
    .wr_addr_i(wr_addr), .wr_dat_i(wr_dat), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_dat_o(dat[0]), .rd_vld_o(vld[0]));

  tech_ram_tp #(.BIT_WIDTH(32), .WORD_DEPTH(12), .RD_LAT(2), .RDW_NEW(1), .INIT_EN(1)) u_b (
    .clk_i(clk), .rst_i(rst), .init_done_o(done[1]), .wr_en_i(wr_en), .wr_bm_i(wr_bm),
    .wr_addr_i(wr_addr), .wr_dat_i(wr_dat), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_dat_o(dat[1]), .rd_vld_o(vld[1]));

  tech_ram_tp #(.BIT_WIDTH(32), .WORD_DEPTH(16), .RD_LAT(2), .RDW_NEW(0), .INIT_EN(0)) u_c (
    .clk_i(clk), .rst_i(rst), .init_done_o(done[2]), .wr_en_i(wr_en), .wr_bm_i(wr_bm),
    .wr_addr_i(wr_addr), .wr_dat_i(wr_dat), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_dat_o(dat[2]), .rd_vld_o(vld[2]));

  function automatic int dep(input int i); return (i == 1) ? 12 : 16; endfunction
  function automatic int lat(input int i); return (i == 0) ? 1 : 2;   endfunction
  function automatic bit rdw(input int i); return (i == 1);           endfunction
  function automatic bit ini(input int i); return (i != 2);           endfunction
  // Edges after reset release before a configuration accepts traffic.
  function automatic int thr(input int i); return ini(i) ? dep(i) : 1; endfunction

  typedef struct {int inst; int due; logic [31:0] d; bit k;} rd_t;
  rd_t         pend[$];
  int          edges [3];
  logic [31:0] mm [3][16];
  logic [3:0]  mk [3][16];
  logic [31:0] last [3];
  bit          lastk [3];
  bit          ev [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    edges[i] = 0; last[i] = '0; lastk[i] = 1'b1; ev[i] = 1'b0;
    for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].inst == i) pend.delete(j);
  endtask

  task automatic model_edge(input int i, input bit r, input bit we, input logic [3:0] bm,
                            input int wa, input logic [31:0] wd, input bit re, input int ra);
    logic [31:0] v;
    logic [3:0]  kv;
    bit          go;
    if (r) begin
      model_reset(i);
      return;
    end
    ev[i] = 1'b0;
    go = edges[i] >= thr(i);
    if (go && !re) begin
      if (ra >= dep(i)) begin
        v = '0; kv = 4'hF;
      end else begin
        v = mm[i][ra]; kv = mk[i][ra];
        if (rdw(i) && !we && wa == ra)
          for (int b = 0; b < 4; b++)
            if (bm[b]) begin v[8*b +: 8] = wd[8*b +: 8]; kv[b] = 1'b1; end
      end
      pend.push_back('{i, edges[i] + lat(i), v, kv == 4'hF});
    end
    if (ini(i) && edges[i] < dep(i)) begin
      mm[i][edges[i]] = '0; mk[i][edges[i]] = 4'hF;
    end else if (go && !we && wa < dep(i)) begin
      for (int b = 0; b < 4; b++)
        if (bm[b]) begin mm[i][wa][8*b +: 8] = wd[8*b +: 8]; mk[i][wa][b] = 1'b1; end
    end
    edges[i]++;
    for (int j = 0; j < pend.size(); j++)
      if (pend[j].inst == i && pend[j].due == edges[i]) begin
        ev[i] = 1'b1; last[i] = pend[j].d; lastk[i] = pend[j].k;
        pend.delete(j);
        break;
      end
  endtask

  task automatic compare(input int i);
    check($sformatf("u%0d.init_done", i), 32'(done[i]), 32'(edges[i] >= thr(i)));
    check($sformatf("u%0d.rd_vld", i), 32'(vld[i]), 32'(ev[i]));
    if (lastk[i]) check($sformatf("u%0d.rd_dat", i), dat[i], last[i]);
  endtask

  task automatic step();
    bit r, we, re;
    logic [3:0] bm;
    int wa, ra;
    logic [31:0] wd;
    r = rst; we = wr_en; re = rd_en; bm = wr_bm; wa = int'(wr_addr); ra = int'(rd_addr); wd = wr_dat;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_edge(i, r, we, bm, wa, wd, re, ra);
      compare(i);
    end
  endtask

  task automatic idle();
    wr_en = 1'b1; rd_en = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b0; wr_addr = a; wr_dat = d; wr_bm = m;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b0; rd_addr = a;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      for (int a = 0; a < 16; a++) begin mm[i][a] = '0; mk[i][a] = 4'h0; end
    end
    rst = 1'b1; wr_bm = '0; wr_addr = '0; rd_addr = '0; wr_dat = '0;
    idle();
    repeat (3) step();
    rst = 1'b0;

    // Traffic during the sweep must not land in the sweeping configurations.
    for (int k = 0; k < 16; k++) begin
      wr(4'($urandom), $urandom, 4'hF);
      rd(4'($urandom));
      if (k == 15) check("init_low_at_15", 32'(done[0]), 32'd0);
      step();
    end
    check("init_high_at_16", 32'(done[0]), 32'd1);
    idle();
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      step();
      check("init_zero", dat[0], 32'h0);
    end
    idle(); step(); step();

    wr(4'd3, 32'hAABBCCDD, 4'hF); step();
    wr(4'd3, 32'h11223344, 4'b0101); step();
    idle(); rd(4'd3); step();
    check("bytemask_dat", dat[0], 32'hAA22CC44);
    check("bytemask_vld", 32'(vld[0]), 32'd1);
    idle(); step();
    check("bytemask_lat2", dat[1], 32'hAA22CC44);

    for (int a = 0; a < 3; a++) begin wr(4'(a), 32'h0A0A0000 + 32'(a), 4'hF); step(); end
    idle();
    for (int a = 0; a < 3; a++) begin rd(4'(a)); step(); end
    idle();
    repeat (3) step();
    check("lat2_hold", dat[1], 32'h0A0A0002);

    wr(4'd5, 32'h12345678, 4'hF); step();
    wr(4'd5, 32'hFFFFFFFF, 4'b0011); rd(4'd5); step();
    check("rdw_old", dat[0], 32'h12345678);
    idle(); step();
    check("rdw_new", dat[1], 32'h1234FFFF);

    wr(4'd13, 32'h5A5A5A5A, 4'hF); step();
    idle(); rd(4'd13); step();
    idle(); step();
    check("oor_rd_dat", dat[1], 32'h0);
    check("oor_rd_vld", 32'(vld[1]), 32'd1);
    for (int a = 0; a < 16; a++) begin rd(4'(a)); step(); end
    idle(); step(); step();

    for (int k = 0; k < 400; k++) begin
      wr_en   = 1'($urandom);
      rd_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      wr_bm   = 4'($urandom);
      wr_dat  = $urandom;
      step();
    end

    wr(4'd1, 32'hDEADBEEF, 4'hF); step();
    idle(); rst = 1'b1; step(); step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin rd(4'd1); step(); end
    check("pre_reset_c_dat", dat[2], 32'hDEADBEEF);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.async_done", i), 32'(done[i]), 32'd0);
      check($sformatf("u%0d.async_vld", i), 32'(vld[i]), 32'd0);
      check($sformatf("u%0d.async_dat", i), dat[i], 32'h0);
      model_reset(i);
    end
    idle(); step(); step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("resweep_low_at_15", 32'(done[0]), 32'd0);
      step();
    end
    check("resweep_high_at_16", 32'(done[0]), 32'd1);
    for (int a = 0; a < 16; a++) begin rd(4'(a)); step(); end
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
